// File: rtl/ex_pkg.sv
// Shared definitions for the sequential step-classifier execution block:
// request opcodes, controller states and the output saturation helper.
package ex_pkg;

    localparam logic [2:0] FUNCT_RST_CNT  = 3'd0;
    localparam logic [2:0] FUNCT_CLASSIFY = 3'd1;
    localparam logic [2:0] FUNCT_WR_W     = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HID  = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Clamp an unsigned value to the largest dw-bit number; caller narrows the result.
    function automatic logic [31:0] sat_dw(input logic [63:0] x, input int unsigned dw);
        logic [63:0] max_v;
        max_v = (64'd1 << dw) - 64'd1;
        if (x > max_v) begin
            return max_v[31:0];
        end else begin
            return x[31:0];
        end
    endfunction

endpackage

// File: rtl/ex_block_seq_mac_unit.sv
// Registered multiply-accumulate: i_clr restarts the sum with the current product,
// o_sat presents the running sum clamped to DW bits.
module mac_unit
    import ex_pkg::*;
#(
    parameter int DW    = 10,
    parameter int ACC_W = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_clr,
    input  logic [DW-1:0] i_x,
    input  logic [DW-1:0] i_w,
    output logic [DW-1:0] o_sat
);

    logic [2*DW-1:0]  w_prod;
    logic [ACC_W-1:0] r_acc;

    assign w_prod = {{DW{1'b0}}, i_x} * {{DW{1'b0}}, i_w};
    assign o_sat  = DW'(sat_dw(64'(r_acc), DW));

    // Accumulator register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= (i_clr ? {ACC_W{1'b0}} : r_acc) + ACC_W'(w_prod);
        end else begin
            r_acc <= r_acc;
        end
    end

endmodule

// File: rtl/ex_block_seq.sv
// Sequential 2-input / N_HID-hidden / 1-output step classifier with a shared MAC,
// on-chip weight registers and a saturating step counter.
module ex_block_seq
    import ex_pkg::*;
#(
    parameter int DW         = 10,
    parameter int N_HID      = 2,
    parameter int CNT_W      = 10,
    parameter int ACT_THRESH = 512,
    parameter int AW         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    input  logic [AW-1:0]    w_addr,
    input  logic [DW-1:0]    w_data,
    output logic             out_valid,
    output logic             step,
    output logic [CNT_W-1:0] step_count,
    output logic             cnt_sat
);

    localparam int ACC_W = 2*DW + $clog2((N_HID > 2) ? N_HID : 2) + 1;
    localparam int NW    = 3*N_HID;

    state_t           r_state;
    logic [AW-1:0]    r_idx;
    logic [DW-1:0]    r_a;
    logic [DW-1:0]    r_b;
    logic [DW-1:0]    r_w      [NW];
    logic [DW-1:0]    r_hidden [N_HID];
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_step;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cnt_sat;

    logic [AW-1:0]    w_j;
    logic [DW-1:0]    w_wsel;
    logic [DW-1:0]    w_hid_stored;
    logic [DW-1:0]    w_hid;
    logic [DW-1:0]    w_x;
    logic             w_en;
    logic             w_clr;
    logic [DW-1:0]    w_sat;

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign step       = r_step;
    assign step_count = r_cnt;
    assign cnt_sat    = r_cnt_sat;
    assign w_j        = r_idx - AW'(2*N_HID);

    // The step index doubles as the weight address: theta in HID, alpha in OUT.
    always_comb begin
        w_wsel       = '0;
        w_hid_stored = '0;
        for (int i = 0; i < NW; i++) begin
            if (r_idx == AW'(i)) begin
                w_wsel = r_w[i];
            end else begin
                w_wsel = w_wsel;
            end
        end
        for (int h = 0; h < N_HID; h++) begin
            if (w_j == AW'(h)) begin
                w_hid_stored = r_hidden[h];
            end else begin
                w_hid_stored = w_hid_stored;
            end
        end
        // With one hidden node its value is still in the MAC on the first OUT cycle.
        w_hid = ((N_HID == 1) && (r_idx == AW'(2*N_HID))) ? w_sat : w_hid_stored;
    end

    // MAC operand and control selection
    always_comb begin
        w_x   = '0;
        w_en  = 1'b0;
        w_clr = 1'b0;
        case (r_state)
            HID: begin
                w_x   = r_idx[0] ? r_b : r_a;
                w_en  = 1'b1;
                w_clr = ~r_idx[0];
            end
            OUT: begin
                w_x   = w_hid;
                w_en  = 1'b1;
                w_clr = (r_idx == AW'(2*N_HID));
            end
            default: begin
                w_x   = '0;
                w_en  = 1'b0;
                w_clr = 1'b0;
            end
        endcase
    end

    mac_unit #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_en),
        .i_clr (w_clr),
        .i_x   (w_x),
        .i_w   (w_wsel),
        .o_sat (w_sat)
    );

    // Controller, weight storage and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_step      <= 1'b0;
            r_cnt       <= '0;
            r_cnt_sat   <= 1'b0;
            for (int i = 0; i < NW; i++) begin
                r_w[i] <= '0;
            end
            for (int h = 0; h < N_HID; h++) begin
                r_hidden[h] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        case (funct)
                            FUNCT_RST_CNT: begin
                                r_cnt     <= '0;
                                r_cnt_sat <= 1'b0;
                            end
                            FUNCT_CLASSIFY: begin
                                r_a        <= a;
                                r_b        <= b;
                                r_idx      <= '0;
                                r_in_ready <= 1'b0;
                                r_state    <= HID;
                            end
                            FUNCT_WR_W: begin
                                for (int i = 0; i < NW; i++) begin
                                    if (w_addr == AW'(i)) begin
                                        r_w[i] <= w_data;
                                    end
                                end
                            end
                            default: begin
                                r_state <= IDLE;
                            end
                        endcase
                    end
                end
                HID: begin
                    // On each even step the MAC holds the finished previous hidden node.
                    for (int h = 0; h < N_HID - 1; h++) begin
                        if (r_idx == AW'(2*h + 2)) begin
                            r_hidden[h] <= w_sat;
                        end
                    end
                    r_idx <= r_idx + AW'(1);
                    if (r_idx == AW'(2*N_HID - 1)) begin
                        r_state <= OUT;
                    end
                end
                OUT: begin
                    if (r_idx == AW'(2*N_HID)) begin
                        r_hidden[N_HID-1] <= w_sat;
                    end
                    r_idx <= r_idx + AW'(1);
                    if (r_idx == AW'(3*N_HID - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_step      <= (w_sat > DW'(ACT_THRESH));
                    r_out_valid <= 1'b1;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                    if (w_sat > DW'(ACT_THRESH)) begin
                        if (r_cnt == {CNT_W{1'b1}}) begin
                            r_cnt_sat <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/ex_block_seq.md
Name: ex_block_seq

Overview:
- Parametrised, sequential successor to the pedometer execution block: a 2-input, N_HID-hidden-node, 1-output feed-forward step classifier with on-chip weight storage and a step counter.
- One shared multiply-accumulate unit is time-multiplexed under an FSM, replacing per-node parallel multipliers.
- Sits after the accelerometer/feature front end. A valid/ready handshake carries FUNCT opcodes for count reset, classify-and-count, and weight write.

Parameters:
- DW, 10, data/weight width (unsigned) for inputs, weights and node outputs
- N_HID, 2, number of hidden nodes (>=1)
- CNT_W, 10, step counter width
- ACT_THRESH, 512, activation threshold; step = (output node > ACT_THRESH)
- AW, 4, weight address width; must satisfy 2^AW >= 3*N_HID

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request (high only in IDLE)
- funct  in  3  0 = reset count, 1 = classify, 2 = write weight, others = no-op
- a  in  DW  input X (classify)
- b  in  DW  input Y (classify)
- w_addr  in  AW  weight address (write weight)
- w_data  in  DW  weight value (write weight)
- out_valid  out  1  one-cycle pulse; step and step_count are valid for a completed classify
- step  out  1  classification result of the last classify
- step_count  out  CNT_W  total steps counted
- cnt_sat  out  1  sticky flag: step_count has saturated

Behaviour:
- Reset (asynchronous, rst=1):
  - FSM goes to IDLE; in_ready=1; out_valid=0; step=0; step_count=0; cnt_sat=0.
  - All weights are cleared to 0; latched a/b and the accumulator are cleared.
  - Reset mid-classify aborts the operation; no out_valid is produced.
- Handshake:
  - A request is accepted on a rising edge with in_valid && in_ready.
  - in_ready is 0 in every state except IDLE.
  - Inputs are sampled only at the accept edge.
- funct 0 (reset count): at the accept edge, step_count <= 0 and cnt_sat <= 0. Stays in IDLE; no out_valid.
- funct 2 (write weight):
  - At the accept edge, weight[w_addr] <= w_data. Stays in IDLE; no out_valid.
  - Address map: theta(h,0) at 2h, theta(h,1) at 2h+1, alpha(h) at 2*N_HID+h.
  - Addresses >= 3*N_HID are ignored.
- funct 3-7: accepted and ignored (no state change).
- funct 1 (classify) FSM: IDLE -> HID -> OUT -> DONE -> IDLE.
  - HID: 2*N_HID cycles. For each h, acc = a*theta(h,0) + b*theta(h,1); hidden[h] = sat_DW(acc).
  - OUT: N_HID cycles. acc = sum over h of hidden[h]*alpha(h); y = sat_DW(acc).
  - DONE: one cycle. At its closing edge: step <= (y > ACT_THRESH), out_valid <= 1, and step_count increments if step. The FSM then returns to IDLE.
  - Latency: accept edge at t, then out_valid is high in the cycle after edge t + 3*N_HID + 1 (7 edges after accept for the defaults). out_valid lasts exactly one cycle.
  - The same edge that raises out_valid raises in_ready, so a back-to-back accept is possible in the cycle where out_valid=1.
- Arithmetic:
  - Products are DW x DW into 2*DW bits; the accumulator is 2*DW + clog2(max(2, N_HID)) + 1 bits, with no wrap.
  - sat_DW(x) = min(x, 2^DW - 1).
- Counter: saturates at 2^CNT_W - 1. cnt_sat is set when an increment is attempted at max; step_count holds at max.
- step holds its value between classifies and is unaffected by funct 0 and funct 2.

Decomposition:
- Shared package ex_pkg:
  - funct encodings FUNCT_RST_CNT=0, FUNCT_CLASSIFY=1, FUNCT_WR_W=2
  - FSM state enum (IDLE, HID, OUT, DONE)
  - sat_DW helper function
- One sub-module, mac_unit: a registered multiply-accumulate with clear/enable inputs and a saturating read-out, parametrised by DW and accumulator width.
- Weight storage is a register array inside ex_block_seq.

Test Plan:
- Latency and basic classify:
  - rst pulse; write all 6 weights = 1; classify a=200, b=200.
  - Expect hidden=400, y=800.
  - out_valid exactly 7 edges after accept; step=1; step_count=1; in_ready=0 during compute.
- Below-threshold classify: weights = 1; a=100, b=100.
  - Expect y=400, step=0, step_count unchanged; out_valid still pulses once.
- Saturation: weights = 1; a=1023, b=1023.
  - Expect hidden saturated to 1023, y saturated to 1023, step=1.
  - Also write theta(0,0)=0 at addr 0 and confirm hidden[0]=b.
- Counter saturation and reset: instance CNT_W=4.
  - 17 step-producing classifies: step_count=15, cnt_sat=1.
  - funct 0: step_count=0, cnt_sat=0, no out_valid.
- Reset mid-operation:
  - Assert rst 3 cycles after a classify accept.
  - Expect no out_valid, all outputs at reset values, weights=0.
  - A subsequent classify gives y=0, step=0.
- Handshake edges:
  - in_valid held during busy: no accept until IDLE.
  - funct 5: no effect.
  - Write to addr 15: ignored.
  - Back-to-back classify accepted in the out_valid cycle.
